// File: rtl/mux_rr_pkg.sv
// Shared constants and helpers for the N-channel registered mux.
// Mode encodings and the select-width rule live here so the bench and RTL agree.
package mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // A select bus is at least one bit wide even for degenerate channel counts.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_rr_nch_rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus last-granted pointer
// in, one-hot grant and binary index out.
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = sel_width(NCH)
) (
  input  logic [NCH-1:0]  i_req,
  input  logic [SELW-1:0] i_ptr,
  output logic [NCH-1:0]  o_grant,
  output logic [SELW-1:0] o_idx,
  output logic            o_any
);

  logic [2*NCH-1:0] w_dbl;
  logic [2*NCH-1:0] w_mask;
  logic [2*NCH-1:0] w_masked;

  // Requests are duplicated so the window ptr+1 .. ptr+NCH never wraps;
  // the lowest set bit inside that window is the winner.
  always_comb begin
    w_dbl    = {i_req, i_req};
    w_mask   = '0;
    for (int j = 0; j < 2 * NCH; j++) begin
      w_mask[j] = (j > int'(i_ptr)) && (j <= int'(i_ptr) + NCH);
    end
    w_masked = w_dbl & w_mask;
  end

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int j = 0; j < 2 * NCH; j++) begin
      if (w_masked[j] && !o_any) begin
        o_any = 1'b1;
        o_idx = SELW'((j >= NCH) ? (j - NCH) : j);
      end
    end
    if (o_any) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mux_rr_nch.sv
// N-channel, W-bit registered multiplexer with fixed or round-robin select and
// valid/ready on every input and on the single output register stage.
module mux_rr_nch
  import mux_rr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = sel_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] mux_in,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     mux_out,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Handshake: a word moves on any clk edge where valid && ready are both high.
  // in_ready is combinational from out_valid/out_ready and the grant; it never
  // depends on in_valid of other channels beyond the arbitration itself.

  logic [WIDTH-1:0] r_mux_out;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;
  logic [SELW-1:0]  r_ptr;

  logic             w_load_en;
  logic [NCH-1:0]   w_fix_grant;
  logic [NCH-1:0]   w_rr_grant;
  logic [SELW-1:0]  w_rr_idx;
  logic             w_rr_any;
  logic [NCH-1:0]   w_grant;
  logic [SELW-1:0]  w_idx;
  logic             w_any;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  assign w_load_en = !r_out_valid || out_ready;

  // An out-of-range select simply never grants.
  always_comb begin
    w_fix_grant = '0;
    if (int'(sel) < NCH) begin
      w_fix_grant[sel] = in_valid[sel];
    end
  end

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  assign w_grant  = (mode == MODE_RR) ? w_rr_grant : w_fix_grant;
  assign w_idx    = (mode == MODE_RR) ? w_rr_idx   : sel;
  assign w_any    = (mode == MODE_RR) ? w_rr_any   : (|w_fix_grant);
  assign w_xfer   = w_load_en && w_any;
  assign in_ready = w_load_en ? w_grant : '0;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (SELW'(i) == w_idx) begin
        w_data = mux_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // The pointer only advances when a round-robin grant is actually consumed,
  // so a stalled output never skips a channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mux_out   <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_ptr       <= SELW'(NCH - 1);
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_mux_out   <= w_data;
        r_out_ch    <= w_idx;
        r_out_valid <= 1'b1;
        if (mode == MODE_RR) begin
          r_ptr <= w_idx;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign mux_out   = r_mux_out;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule
